// File: rtl/hapara_lmb_dma_bcast.sv
// Buffered DMA-to-LMB broadcast.
// Full-word DMA writes are queued. Each queued word is written into every
// slave BRAM on a cycle when that slave's port is idle. A per-channel
// starvation counter forces the write through when a slave stays busy.
module hapara_lmb_dma_bcast #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLAVE    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                              clk_ctrl,
    input  logic                              rst_ctrl,
    // DMA controller port
    input  logic [DATA_WIDTH-1:0]             addr_ctrl,
    input  logic [DATA_WIDTH-1:0]             data_in_ctrl,
    output logic [DATA_WIDTH-1:0]             data_out_ctrl,
    input  logic [DATA_WIDTH/8-1:0]           we_ctrl,
    input  logic                              en_ctrl,
    // status
    output logic                              fifo_full,
    output logic                              idle,
    output logic [$clog2(FIFO_DEPTH):0]       pending,
    output logic                              overflow,
    // slave LMB ports
    input  logic [NUM_SLAVE*DATA_WIDTH-1:0]   addr_s,
    input  logic [NUM_SLAVE*DATA_WIDTH-1:0]   data_in_s,
    output logic [NUM_SLAVE*DATA_WIDTH-1:0]   data_out_s,
    input  logic [NUM_SLAVE*DATA_WIDTH/8-1:0] we_s,
    input  logic [NUM_SLAVE-1:0]              en_s,
    output logic [NUM_SLAVE-1:0]              stall_s,
    // BRAM ports
    output logic [NUM_SLAVE*DATA_WIDTH-1:0]   addr_b,
    output logic [NUM_SLAVE*DATA_WIDTH-1:0]   data_in_b,
    input  logic [NUM_SLAVE*DATA_WIDTH-1:0]   data_out_b,
    output logic [NUM_SLAVE*DATA_WIDTH/8-1:0] we_b,
    output logic [NUM_SLAVE-1:0]              en_b,
    output logic [NUM_SLAVE-1:0]              clk_b,
    output logic [NUM_SLAVE-1:0]              rst_b
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    // Queue storage. The head is read asynchronously so a word pushed in
    // cycle N can already be broadcast in cycle N+1.
    logic [DATA_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  overflow_reg;

    logic                  push;
    logic                  full;
    logic                  accept;
    logic                  pop;
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [NUM_SLAVE-1:0]  inj;
    logic [NUM_SLAVE-1:0]  done_vec;

    // Only full-word writes are broadcast; partial writes and reads are ignored.
    assign push       = en_ctrl & (&we_ctrl) & ~rst_ctrl;
    assign full       = (count_reg == CW'(FIFO_DEPTH));
    // Injection is suppressed while reset is asserted so BRAMs see pure slave traffic.
    assign head_valid = (count_reg != '0) & ~rst_ctrl;
    assign head_addr  = addr_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];

    // The head retires once every channel has it, either from an earlier
    // cycle or by injecting it now.
    assign pop        = head_valid & (&(done_vec | inj));
    // When full, a write still fits if the head leaves in the same cycle.
    assign accept     = push & (~full | pop);

    assign data_out_ctrl = '0;
    assign fifo_full     = full;
    assign idle          = (count_reg == '0);
    assign pending       = count_reg;
    assign overflow      = overflow_reg;

    // Queue memory write port; no reset needed on storage.
    always_ff @(posedge clk_ctrl) begin
        if (accept) begin
            addr_mem[wr_ptr_reg] <= addr_ctrl;
            data_mem[wr_ptr_reg] <= data_in_ctrl;
        end
    end

    // Queue pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (accept && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !accept) begin
                count_reg <= count_reg - CW'(1);
            end
            if (push && !accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVE; gi++) begin : g_ch
            logic       done_reg;
            logic [7:0] starve_reg;
            logic       starve_hit;
            logic       waiting;

            assign starve_hit   = (starve_reg == STARVE_MAX);
            // Channel still owes the head a write.
            assign waiting      = head_valid & ~done_reg;
            // Write opportunistically on an idle slave cycle, or force it
            // once the slave has kept the port busy long enough.
            assign inj[gi]      = waiting & (~en_s[gi] | starve_hit);
            assign stall_s[gi]  = inj[gi] & en_s[gi];
            assign done_vec[gi] = done_reg;

            assign addr_b[gi*DATA_WIDTH +: DATA_WIDTH] =
                inj[gi] ? head_addr : addr_s[gi*DATA_WIDTH +: DATA_WIDTH];
            assign data_in_b[gi*DATA_WIDTH +: DATA_WIDTH] =
                inj[gi] ? head_data : data_in_s[gi*DATA_WIDTH +: DATA_WIDTH];
            assign we_b[gi*BW +: BW] = inj[gi] ? {BW{1'b1}} : we_s[gi*BW +: BW];
            assign en_b[gi]          = inj[gi] | en_s[gi];
            assign data_out_s[gi*DATA_WIDTH +: DATA_WIDTH] =
                data_out_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign clk_b[gi] = clk_ctrl;
            assign rst_b[gi] = rst_ctrl;

            // Per-channel head bookkeeping: done flag and starvation counter.
            always_ff @(posedge clk_ctrl) begin
                if (rst_ctrl) begin
                    done_reg   <= 1'b0;
                    starve_reg <= '0;
                end else if (pop) begin
                    done_reg   <= 1'b0;
                    starve_reg <= '0;
                end else if (inj[gi]) begin
                    done_reg   <= 1'b1;
                    starve_reg <= '0;
                end else if (waiting && en_s[gi] && !starve_hit) begin
                    starve_reg <= starve_reg + 8'd1;
                end
            end
        end
    endgenerate

endmodule
